// File: rtl/cpu_pkg.sv
// Shared datapath definitions: data width, divider FSM states, ALU mux select codes.
package cpu_pkg;

    // Native datapath operand width.
    localparam int DATA_W = 32;

    // Width of the 16-input ALU result mux select.
    localparam int ALU_SEL_W = 4;

    // Mux input that carries the divider's {remainder, quotient} result.
    localparam logic [ALU_SEL_W-1:0] ALU_SEL_DIV = 4'd5;

    // Sequential divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational radix-2 restoring division iteration on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] remNext,
    output logic [WIDTH-1:0] quoNext
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Shift {R, Q} left by one, then try subtracting the divisor from the partial remainder.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        if (!trial[WIDTH]) begin
            remNext = trial[WIDTH-1:0];
            quoNext = {quo[WIDTH-2:0], 1'b1};
        end else begin
            remNext = shifted[WIDTH-1:0];
            quoNext = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: one quotient bit per clock, start/busy/done handshake.
// result = {remainder, quotient}; quotient truncates toward zero, remainder follows
// the dividend's sign. Divide by zero yields quotient all ones, remainder = dividend.
module seq_divider
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    div_state_t state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] divReg;
    logic [WIDTH-1:0] origDividend;
    logic             qNeg;
    logic             rNeg;
    logic             dbz;

    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;
    logic [WIDTH-1:0] quoFixed;
    logic [WIDTH-1:0] remFixed;

    // Magnitude as unsigned; the most negative value maps onto itself, which is correct unsigned.
    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    div_step #(
        .WIDTH (WIDTH)
    ) uStep (
        .rem     (remReg),
        .quo     (quoReg),
        .dvs     (divReg),
        .remNext (remNext),
        .quoNext (quoNext)
    );

    // Apply the captured signs to the unsigned quotient and remainder (wrapping).
    always_comb begin
        quoFixed = qNeg ? (~quoReg + 1'b1) : quoReg;
        remFixed = rNeg ? (~remReg + 1'b1) : remReg;
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state        <= IDLE;
            count        <= '0;
            remReg       <= '0;
            quoReg       <= '0;
            divReg       <= '0;
            origDividend <= '0;
            qNeg         <= 1'b0;
            rNeg         <= 1'b0;
            dbz          <= 1'b0;
            result       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_by_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        remReg       <= '0;
                        quoReg       <= absVal(dividend);
                        divReg       <= absVal(divisor);
                        origDividend <= dividend;
                        qNeg         <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rNeg         <= dividend[WIDTH-1];
                        dbz          <= (divisor == '0);
                        count        <= '0;
                        busy         <= 1'b1;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    remReg <= remNext;
                    quoReg <= quoNext;
                    count  <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dbz) begin
                        result <= {origDividend, {WIDTH{1'b1}}};
                    end else begin
                        result <= {remFixed, quoFixed};
                    end
                    div_by_zero <= dbz;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, random vs. arithmetic model, corner sequences.
module tb_seq_divider;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [63:0] result;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_divider #(
        .WIDTH (32)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .result      (result),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expQ;
        logic [31:0] expR;
        logic        expDbz;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Signed division from plain arithmetic: {dbz, remainder, quotient}.
    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    // Run one divide; report result, flag, edges to done, busy cycles, result right after capture,
    // and done level one cycle after the pulse.
    task automatic runDiv(input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output logic dbzOut, output int lat,
                          output int busyCnt, output logic [63:0] resAtStart,
                          output logic doneAfter);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        lat        = 1;
        busyCnt    = busy ? 1 : 0;
        resAtStart = result;
        @(negedge clock);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        while (!done && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
            if (busy) busyCnt++;
        end
        res    = result;
        dbzOut = div_by_zero;
        @(posedge clock);
        #1;
        doneAfter = done;
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] resAtStart;
        logic [63:0] prevRes;
        logic [64:0] m;
        logic        dbzOut;
        logic        doneAfter;
        int          lat;
        int          busyCnt;
        int          donePulses;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{32'd100,       32'd7,          32'h0000_000E, 32'h0000_0002, 1'b0};
        vecs[1] = '{-32'sd100,     32'd7,          32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
        vecs[2] = '{32'd100,       -32'sd7,        32'hFFFF_FFF2, 32'h0000_0002, 1'b0};
        vecs[3] = '{32'd5,         32'd0,          32'hFFFF_FFFF, 32'h0000_0005, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[5] = '{32'd0,         32'd9,          32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[6] = '{32'd7,         32'd100,        32'h0000_0000, 32'h0000_0007, 1'b0};
        vecs[7] = '{-32'sd7,       -32'sd2,        32'h0000_0003, 32'hFFFF_FFFF, 1'b0};

        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        clear    = 1'b1;
        #1;
        check("reset_result", result, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        #22;
        clear = 1'b0;

        prevRes = 64'd0;
        foreach (vecs[i]) begin
            runDiv(vecs[i].a, vecs[i].b, res, dbzOut, lat, busyCnt, resAtStart, doneAfter);
            check($sformatf("vec%0d_result", i), res, {vecs[i].expR, vecs[i].expQ});
            check($sformatf("vec%0d_dbz", i), {63'd0, dbzOut}, {63'd0, vecs[i].expDbz});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
            check($sformatf("vec%0d_busy_cycles", i), 64'(busyCnt), 64'd33);
            check($sformatf("vec%0d_hold_at_start", i), resAtStart, prevRes);
            check($sformatf("vec%0d_done_one_cycle", i), {63'd0, doneAfter}, 64'd0);
            prevRes = res;
        end

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 20);
                2:       rb = -$urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            if (i % 5 == 0) ra = ra >> $urandom_range(0, 31);
            m = model(ra, rb);
            runDiv(ra, rb, res, dbzOut, lat, busyCnt, resAtStart, doneAfter);
            check($sformatf("rand%0d_result a=%0h b=%0h", i, ra, rb), res, m[63:0]);
            check($sformatf("rand%0d_dbz", i), {63'd0, dbzOut}, {63'd0, m[64]});
        end

        // Start pulse during CALC must be ignored.
        @(negedge clock);
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        donePulses = 0;
        for (int c = 0; c < 45; c++) begin
            if (c == 9) begin
                dividend = 32'd77;
                divisor  = 32'd5;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
            if (done) begin
                donePulses++;
                check("ignore_result", result, {32'd1, 32'd333});
            end
            @(negedge clock);
        end
        start = 1'b0;
        check("ignore_done_pulses", 64'(donePulses), 64'd1);
        check("ignore_result_held", result, {32'd1, 32'd333});

        // Asynchronous clear in the middle of CALC.
        @(negedge clock);
        dividend = 32'd123456;
        divisor  = 32'd789;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (15) @(negedge clock);
        #2;
        clear = 1'b1;
        #1;
        check("clear_busy", {63'd0, busy}, 64'd0);
        check("clear_done", {63'd0, done}, 64'd0);
        check("clear_result", result, 64'd0);
        @(negedge clock);
        clear = 1'b0;
        donePulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (done || busy) donePulses++;
        end
        check("clear_no_done", 64'(donePulses), 64'd0);
        m = model(32'd123456, 32'd789);
        runDiv(32'd123456, 32'd789, res, dbzOut, lat, busyCnt, resAtStart, doneAfter);
        check("after_clear_result", res, m[63:0]);
        check("after_clear_latency", 64'(lat), 64'd34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
